imem_loader: RTL
================

# imem_loader

Sequential program loader that writes the instruction memory, the write side of the interface the single-cycle MIPS datapath reads each cycle through the PC. Accepts a big-endian byte stream over a valid/ready handshake, packs it into 32-bit instruction words, and issues one-cycle word writes at byte addresses 0, 4, 8, … Holds the datapath in reset (`core_rst`) while a load is in progress, so the PC restarts at 0 on fresh code.

## Interface
- `DEPTH_WORDS`, 64: instruction memory capacity in 32-bit words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; honoured only in IDLE or ERR.
- `in_valid`  in  1  byte present on `in_byte`.
- `in_byte`  in  8  program byte, big-endian: the first byte of a word goes to [31:24].
- `in_last`  in  1  qualifies the final byte of the program, sampled with the handshake.
- `in_ready`  out  1  loader can accept a byte.
- `wr_en`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr`  out  32  byte address of the word, a multiple of 4.
- `wr_data`  out  32  assembled instruction word.
- `core_rst`  out  1  reset to PC and datapath.
- `busy`  out  1  load in progress (RECV or WRITE).
- `done`  out  1  sticky; last load completed cleanly.
- `err`  out  1  sticky; last load aborted.

## Operation
- **States:** IDLE, RECV, WRITE, ERR.
- **IDLE**
  - `in_ready`=0, `core_rst`=0.
  - On `start`: clear `done` and `err`, set address to 0 and byte count to 0, go to RECV.
- **RECV**
  - `in_ready`=1, `core_rst`=1.
  - A byte is accepted when `in_valid` && `in_ready`. It shifts into the word register (`word <= {word[23:0], in_byte}`) and the byte count increments modulo 4.
  - 4th byte accepted:
    - If word index < `DEPTH_WORDS`, go to WRITE and latch `last` = `in_last`.
    - Otherwise go to ERR.
  - `in_last` on byte 1–3 of a word (partial word): go to ERR with no write.
- **WRITE**
  - `wr_en`=1 for exactly one cycle, with `wr_addr` = current address and `wr_data` = word.
  - The address then advances by 4, using 32-bit arithmetic.
  - If `last`: set `done`, go to IDLE. Otherwise return to RECV.
- **ERR**
  - `err`=1, `core_rst`=1, `in_ready`=0.
  - Leaves only on `start` (same as from IDLE) or `rst`.
- `start` while in RECV or WRITE is ignored.
- `in_byte` is ignored whenever `in_ready`=0.
- Exactly `DEPTH_WORDS` words followed by `in_last` is legal. The ERR overflow check applies only to word `DEPTH_WORDS`+1.

## Timing
- **Reset values** (every output registered): `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_rst`=1, `busy`=0, `done`=0, `err`=0.
  - The state after reset is IDLE.
  - `core_rst` falls in the first cycle after `rst` deasserts.
- `in_ready` is computed from the next state:
  - It is high the cycle after `start` is sampled.
  - It is low in the cycle immediately after the 4th byte is accepted.
- **Throughput:** 5 cycles per word at full rate (4 accept cycles, then 1 WRITE cycle).
- **Latency:** `wr_en` rises the cycle after the 4th byte is accepted.
- `done` rises in the cycle after the final WRITE, together with `core_rst` falling. The datapath fetches address 0 on the following edge.
- `rst` mid-load returns to IDLE with reset values on the next edge. A partial word is discarded and nothing is written.
- `start` and `rst` in the same cycle: `rst` wins.

## Structure
- Package `imem_loader_pkg`:
  - state enum `loader_state_t` {IDLE, RECV, WRITE, ERR}
  - `BYTES_PER_WORD`=4
  - `PC_STEP`=32'd4, shared with the PC adder constant.
- Sub-module `word_assembler`:
  - 32-bit shift register plus 2-bit byte counter.
  - Inputs: `clk`, `rst`, `clr`, `shift`, `in_byte`.
  - Outputs: `word`, `full`.
- The top-level contains the FSM, the address counter, and the output registers.

## Test plan
- **Single word:** `start`, then bytes 0x01,0x2A,0x40,0x20 with `in_last` on the last byte. Expect exactly one `wr_en`, `wr_addr`=0, `wr_data`=0x012A4020. Then `done`=1 and `core_rst` falls in the same cycle.
- **Three words with `in_valid` gaps:** random idle cycles between bytes. Expect writes at 0, 4, 8 in order, with the correct big-endian data, and no `wr_en` during idle cycles.
- **Partial word:** `in_last` on the 2nd byte. Expect no `wr_en`, `err`=1, `core_rst` held at 1, `in_ready`=0. A following `start` clears `err` and a reload succeeds.
- **Overflow:** `DEPTH_WORDS`=2, send 3 words. Expect writes at 0 and 4, then ERR after the 12th byte, with no write at 8.
- **Reset mid-load:** assert `rst` after byte 2 of word 1. Expect all outputs at reset values next cycle and no write. `start` then restarts at address 0.
- **Protocol:** `start` during RECV is ignored. Back-to-back full-rate stream: `in_ready` low exactly one cycle per word, giving 5 cycles per word.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = 2;

    // Byte stride between consecutive instruction words; matches the PC adder.
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        ERR   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; full means three bytes are held.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    logic [CNT_W-1:0] cnt;

    // Shift register and byte counter; full flags that the next byte completes a word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (shift) begin
            word <= {word[WORD_W-BYTE_W-1:0], in_byte};
            cnt  <= cnt + CNT_W'(1);
            full <= (cnt == CNT_W'(BYTES_PER_WORD - 2));
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t     state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              last, last_n;
    logic              done_n, err_n;
    logic              clr, shift, accept, room;
    logic              full;

    word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .shift   (shift),
        .in_byte (in_byte),
        .word    (wr_data),
        .full    (full)
    );

    assign accept  = (state == RECV) && in_valid && in_ready;
    assign room    = (addr[ADDR_W-1:2] < (ADDR_W-2)'(DEPTH_WORDS));
    assign wr_addr = addr;

    // Next-state, bookkeeping and assembler control.
    always_comb begin
        state_n = state;
        addr_n  = addr;
        last_n  = last;
        done_n  = done;
        err_n   = err;
        clr     = 1'b0;
        shift   = 1'b0;
        unique case (state)
            IDLE, ERR: begin
                if (start) begin
                    clr     = 1'b1;
                    addr_n  = '0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    state_n = RECV;
                end
            end
            RECV: begin
                shift = accept;
                if (accept) begin
                    if (full) begin
                        if (room) begin
                            state_n = WRITE;
                            last_n  = in_last;
                        end else begin
                            state_n = ERR;
                            err_n   = 1'b1;
                        end
                    end else if (in_last) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
            end
            WRITE: begin
                addr_n = addr + PC_STEP;
                if (last) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = RECV;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, address and output registers; handshake/strobe outputs follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            last     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            core_rst <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            last     <= last_n;
            done     <= done_n;
            err      <= err_n;
            in_ready <= (state_n == RECV);
            wr_en    <= (state_n == WRITE);
            core_rst <= (state_n != IDLE);
            busy     <= (state_n == RECV) || (state_n == WRITE);
        end
    end

endmodule
